// File: rtl/feature_vector_loader.sv
// Serial-to-parallel front end: collects N_FEAT samples into a fill buffer and
// hands them to the core as a held vector with a Start level, double buffered.
module feature_vector_loader #(
  parameter int unsigned N_FEAT            = 10,
  parameter int unsigned DW                = 10,
  parameter logic [15:0] FRAME_COUNT_RESET = '0
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          SampleValid,
  input  logic [DW-1:0] SampleData,
  output logic          SampleReady,
  input  logic          Done,
  output logic [DW-1:0] VecOut [0:N_FEAT-1],
  output logic          Start,
  output logic          Overrun,
  output logic [15:0]   FrameCount
);

  localparam int unsigned   IW   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_FEAT - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   fb [0:N_FEAT-1];
  logic            transfer;

  assign SampleReady = (state == FILL);
  // A Done in the same cycle as a pending transfer frees the slot and refills it at once.
  assign transfer    = (state == FULL) && (!Start || Done);

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state      <= FILL;
      idx        <= '0;
      fb         <= '{default: '0};
      VecOut     <= '{default: '0};
      Start      <= 1'b0;
      Overrun    <= 1'b0;
      FrameCount <= FRAME_COUNT_RESET;
    end else begin
      if (SampleValid && !SampleReady)
        Overrun <= 1'b1;
      if (Done && Start && !transfer)
        Start <= 1'b0;
      case (state)
        FILL: begin
          if (SampleValid) begin
            fb[idx] <= SampleData;
            if (idx == LAST) begin
              idx   <= '0;
              state <= FULL;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FULL: begin
          if (transfer) begin
            VecOut     <= fb;
            Start      <= 1'b1;
            FrameCount <= FrameCount + 16'd1;
            state      <= FILL;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/feature_vector_loader.md
# feature_vector_loader

Serial-to-parallel front end for the drowsiness detector core. Accepts one feature sample per handshake, assembles `N_FEAT` samples into a vector, and presents that vector on the core's `in` array together with a `Start` level. The vector and `Start` are held until the core returns `Done`. Double buffering lets the next frame fill while the core works on the current one.

## Interface
- `N_FEAT`, default 10: samples per vector.
- `DW`, default 10: sample width in bits. Samples are treated as unsigned and passed through unchanged.
- `Clock`  in  1  single clock; all logic updates on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `SampleValid`  in  1  upstream sample present.
- `SampleData`  in  DW  sample value.
- `SampleReady`  out  1  loader accepts a sample this cycle.
- `Done`  in  1  one-cycle pulse from the core: current vector consumed.
- `VecOut`  out  DW × N_FEAT  array [0:N_FEAT-1]; drives the core's `in`.
- `Start`  out  1  `VecOut` is valid; held high until consumed.
- `Overrun`  out  1  sticky: a sample arrived while `SampleReady` was low.
- `FrameCount`  out  16  number of vectors transferred to `VecOut`.

## Operation
- Storage:
  - Fill buffer `fb[0:N_FEAT-1]`.
  - Write index `idx`, `clog2(N_FEAT)` bits.
  - Output register `VecOut`.
- State machine, two states: FILL and FULL.
- **FILL**
  - `SampleReady` = 1.
  - On `SampleValid`: `fb[idx] <= SampleData`.
  - If `idx == N_FEAT-1`: `idx <= 0` and go to FULL. Otherwise `idx <= idx+1`.
- **FULL**
  - `SampleReady` = 0.
  - Transfer condition is slot free: `Start == 0`, or `Done == 1` this cycle.
  - On transfer:
    - `VecOut <= fb`.
    - `Start <= 1`.
    - `FrameCount <= FrameCount+1`.
    - Go to FILL.
  - Otherwise stay in FULL.
- **Done handling** (any state)
  - `Done` with `Start == 1` and no transfer this edge: `Start <= 0`. `VecOut` holds its value.
  - `Done` with `Start == 0`: ignored.
- **Overrun**
  - `SampleValid && !SampleReady` sets `Overrun <= 1`.
  - The sample is dropped. `fb` and `idx` are unchanged.
  - Cleared only by `Rst`.
- `FrameCount` wraps from 65535 to 0. No flag is raised on wrap.
- `VecOut` changes only on a transfer edge. It is stable for the whole time `Start` is high.

## Timing
- Reset values:
  - state FILL, `idx` 0, `fb` all 0.
  - `VecOut` all 0, `Start` 0, `Overrun` 0, `FrameCount` 0.
  - `SampleReady` is 1 on the first cycle after `Rst` deasserts.
- `Rst` mid-fill or mid-hold:
  - The partial frame and the held vector are discarded.
  - `Start` drops at that edge.
  - `Done` arriving in the same cycle as `Rst` is ignored.
- Latency, last sample accepted to `Start` high:
  - 2 edges when the slot is free: edge 1 enters FULL, edge 2 transfers.
  - Back-to-back case: the core pulses `Done` while the loader is in FULL. The transfer happens on that same edge, and `Start` stays continuously high with the new `VecOut`.
- Throughput:
  - One sample per cycle while in FILL.
  - Minimum N_FEAT+1 cycles per frame.
- `SampleReady` is combinational from state only. It never depends on `SampleValid`.

## Test plan
- **Reset and single frame.** After reset, stream 10 samples 200,201,…,209 on consecutive cycles.
  - Required: `SampleReady` low for exactly 1 cycle after sample 209.
  - Required: `Start` rises 2 edges after the last accept, with `VecOut` = {200..209} and `FrameCount` = 1.
- **Hold and release.** Withhold `Done`, then stream a second frame of 10×300.
  - Required: loader stalls in FULL with `SampleReady` = 0, and `VecOut` stays {200..209}.
  - Required: on `Done`, at the same edge, `VecOut` = 10×300, `Start` stays 1, `FrameCount` = 2.
- **Done with nothing pending.** With the fill buffer half full (5 samples) and `Start` = 1, pulse `Done`.
  - Required: `Start` → 0 next edge and `VecOut` unchanged.
  - Required: after 5 more samples, transfer occurs 2 edges after the last accept.
- **Overrun.** Assert `SampleValid` = 1 with data 999 for 3 cycles while in FULL.
  - Required: `Overrun` = 1 from the next edge and stays 1; 999 never appears in `VecOut`.
  - Required: `Overrun` clears only after `Rst`.
- **Reset mid-operation.** Assert `Rst` after 7 samples of a frame, while `Start` = 1.
  - Required: next edge `Start` = 0, `VecOut` all 0, `FrameCount` = 0.
  - Required: a fresh 10-sample frame then produces a correct vector, with no carry-over from the 7 old samples.
- **Wrap.** Force 65536 transfers (or preload the counter to 65535 in a fast-sim configuration).
  - Required: `FrameCount` goes 65535 → 0 and `Start` behaviour is unaffected.
